// File: rtl/run_rounds.sv
// SHA-256 compression engine: loads H0..H7, pulls W[0..63] from the gen_w read port,
// runs 64 rounds and presents the feed-forward digest with done.
module run_rounds #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         local_go_sig,
  input  logic [255:0] hash_in,
  input  logic         w_reg_rdy,
  input  logic [31:0]  w_reg_data,
  output logic         w_reg_read,
  output logic [5:0]   w_reg_addr,
  output logic [255:0] hash_out,
  output logic         done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HASH_W = 256;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ROUND = ADDR_W'(63);
  localparam logic [WAIT_W-1:0] LAST_WAIT  = WAIT_W'(RD_LAT - 1);

  localparam logic [WORD_W-1:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_RDY, REQ, WAIT, ROUND, FINAL, DONE
  } state_t;

  state_t state, next_state;

  logic                regip_go;
  logic [WORD_W-1:0]   a, b, c, d, e, f, g, h;
  logic [ADDR_W-1:0]   round;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WORD_W-1:0]   w_q;
  logic [HASH_W-1:0]   hin_q;

  logic [WORD_W-1:0]   t1_c, t2_c;
  logic [HASH_W-1:0]   digest_c;
  logic                w_reg_read_c;
  logic [ADDR_W-1:0]   w_reg_addr_c;
  logic [HASH_W-1:0]   hash_out_c;
  logic                done_c;

  function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  // Round arithmetic and feed-forward sum
  always_comb begin
    t1_c = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + K_ROM[round] + w_q;
    t2_c = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    digest_c = {hin_q[255:224] + a, hin_q[223:192] + b,
                hin_q[191:160] + c, hin_q[159:128] + d,
                hin_q[127:96]  + e, hin_q[95:64]   + f,
                hin_q[63:32]   + g, hin_q[31:0]    + h};
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (regip_go) next_state = LOAD;
      LOAD:     next_state = WAIT_RDY;
      WAIT_RDY: if (w_reg_rdy) next_state = REQ;
      REQ:      next_state = WAIT;
      WAIT:     if (wait_cnt == LAST_WAIT) next_state = ROUND;
      ROUND:    next_state = (round == LAST_ROUND) ? FINAL : REQ;
      FINAL:    next_state = DONE;
      DONE:     if (!regip_go) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_reg_read_c = 1'b0;
    w_reg_addr_c = w_reg_addr;
    hash_out_c   = hash_out;
    done_c       = 1'b0;
    unique case (state)
      REQ: begin
        w_reg_read_c = 1'b1;
        w_reg_addr_c = round;
      end
      FINAL:   hash_out_c = digest_c;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_reg_read <= 1'b0;
      w_reg_addr <= '0;
      hash_out   <= '0;
      done       <= 1'b0;
    end else begin
      w_reg_read <= w_reg_read_c;
      w_reg_addr <= w_reg_addr_c;
      hash_out   <= hash_out_c;
      done       <= done_c;
    end
  end

  // Working variables, round/wait counters and W capture
  always_ff @(posedge clock) begin
    if (reset) begin
      regip_go <= 1'b0;
      {a, b, c, d, e, f, g, h} <= '0;
      round    <= '0;
      wait_cnt <= '0;
      w_q      <= '0;
      hin_q    <= '0;
    end else begin
      regip_go <= local_go_sig;
      unique case (state)
        LOAD: begin
          {a, b, c, d, e, f, g, h} <= hash_in;
          hin_q <= hash_in;
          round <= '0;
        end
        REQ: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (wait_cnt == LAST_WAIT) w_q <= w_reg_data;
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1_c;
          d <= c;
          c <= b;
          b <= a;
          a <= t1_c + t2_c;
          if (round != LAST_ROUND) round <= round + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_rounds.sv
// Directed bench for run_rounds: known SHA-256 digests, read-port trace, ready stall,
// mid-run reset and a two-block chain against a reference compression function.
module tb_run_rounds;

  logic         clock;
  logic         reset;
  logic         local_go_sig;
  logic [255:0] hash_in;
  logic         w_reg_rdy;
  logic [31:0]  w_reg_data;
  logic         w_reg_read;
  logic [5:0]   w_reg_addr;
  logic [255:0] hash_out;
  logic         done;

  run_rounds #(.RD_LAT(2)) dut (
    .clock(clock), .reset(reset), .local_go_sig(local_go_sig), .hash_in(hash_in),
    .w_reg_rdy(w_reg_rdy), .w_reg_data(w_reg_data), .w_reg_read(w_reg_read),
    .w_reg_addr(w_reg_addr), .hash_out(hash_out), .done(done)
  );

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_rise = -1;
  logic done_prev = 1'b0;
  logic [31:0] wmem [64];
  int pulse_cyc [$];
  int pulse_addr [$];
  logic [511:0] blk_abc;
  logic [511:0] blk_empty;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // W register file model: data presented the cycle after a read pulse, held until the next one
  initial begin
    forever begin
      @(negedge clock);
      cyc = cyc + 1;
      if (w_reg_read === 1'b1) begin
        w_reg_data = wmem[w_reg_addr];
        pulse_cyc.push_back(cyc);
        pulse_addr.push_back(int'(w_reg_addr));
      end
      if (done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
      done_prev = done;
    end
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic load_w(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) wmem[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      wmem[t] = (rotr(wmem[t-2], 17) ^ rotr(wmem[t-2], 19) ^ (wmem[t-2] >> 10)) + wmem[t-7]
              + (rotr(wmem[t-15], 7) ^ rotr(wmem[t-15], 18) ^ (wmem[t-15] >> 3)) + wmem[t-16];
  endtask

  function automatic logic [255:0] model_compress(input logic [255:0] hin);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wmem[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = v[i] + hin[255 - 32*i -: 32];
    return r;
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic start_run(input logic [255:0] hin, input logic [511:0] blk, input logic rdy);
    load_w(blk);
    pulse_cyc.delete();
    pulse_addr.delete();
    done_rise = -1;
    hash_in = hin;
    w_reg_rdy = rdy;
    local_go_sig = 1'b1;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic release_go();
    local_go_sig = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b0) break;
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    local_go_sig = 1'b0;
    w_reg_rdy = 1'b0;
    hash_in = '0;
    w_reg_data = '0;
    repeat (3) tick();
    total++; if (w_reg_read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b want=0", w_reg_read); end
    total++; if (w_reg_addr !== 6'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", w_reg_addr); end
    total++; if (hash_out !== 256'd0) begin bad++; $display("FAIL reset_hash got=%h want=0", hash_out); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_abc();
    bit to;
    start_run(IV, blk_abc, 1'b1);
    wait_done(to);
    total++; if (to) begin bad++; $display("FAIL abc_timeout got=no_done want=done"); end
    total++; if (hash_out !== ABC_DIGEST) begin bad++; $display("FAIL abc_digest got=%h want=%h", hash_out, ABC_DIGEST); end
    release_go();
  endtask

  task automatic test_empty();
    bit to;
    start_run(IV, blk_empty, 1'b1);
    wait_done(to);
    total++; if (to) begin bad++; $display("FAIL empty_timeout got=no_done want=done"); end
    total++; if (hash_out !== EMPTY_DIGEST) begin bad++; $display("FAIL empty_digest got=%h want=%h", hash_out, EMPTY_DIGEST); end
    release_go();
  endtask

  task automatic test_read_trace();
    bit to;
    int bad_addr, bad_gap, held;
    start_run(IV, blk_abc, 1'b1);
    wait_done(to);
    total++; if (to) begin bad++; $display("FAIL trace_timeout got=no_done want=done"); end
    total++; if (pulse_cyc.size() != 64) begin bad++; $display("FAIL trace_count got=%0d want=64", pulse_cyc.size()); end
    bad_addr = -1;
    bad_gap = -1;
    for (int i = 0; i < pulse_addr.size(); i++) begin
      if (bad_addr < 0 && pulse_addr[i] != i) bad_addr = i;
      if (bad_gap < 0 && i > 0 && pulse_cyc[i] - pulse_cyc[i-1] != 4) bad_gap = i;
    end
    total++; if (bad_addr >= 0) begin bad++; $display("FAIL trace_addr at pulse %0d got=%0d want=%0d", bad_addr, pulse_addr[bad_addr], bad_addr); end
    total++; if (bad_gap >= 0) begin bad++; $display("FAIL trace_gap at pulse %0d got=%0d want=4", bad_gap, pulse_cyc[bad_gap] - pulse_cyc[bad_gap-1]); end
    if (pulse_cyc.size() > 0) begin
      total++;
      if (done_rise - pulse_cyc[0] != 257) begin
        bad++; $display("FAIL trace_done_latency got=%0d want=257", done_rise - pulse_cyc[0]);
      end
    end
    held = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) held++;
    end
    total++; if (held != 20) begin bad++; $display("FAIL trace_done_hold got=%0d want=20", held); end
    total++; if (pulse_cyc.size() != 64) begin bad++; $display("FAIL trace_no_extra_reads got=%0d want=64", pulse_cyc.size()); end
    release_go();
  endtask

  task automatic test_rdy_stall();
    bit to;
    int raise_cyc;
    start_run(IV, blk_abc, 1'b0);
    repeat (10) tick();
    total++; if (pulse_cyc.size() != 0) begin bad++; $display("FAIL stall_no_read got=%0d want=0", pulse_cyc.size()); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL stall_done got=%b want=0", done); end
    w_reg_rdy = 1'b1;
    raise_cyc = cyc;
    tick();
    tick();
    total++;
    if (pulse_cyc.size() != 1 || pulse_cyc[0] != raise_cyc + 2) begin
      bad++; $display("FAIL stall_first_pulse got=%0d pulses want=1 at +2", pulse_cyc.size());
    end
    total++;
    if (pulse_addr.size() < 1 || pulse_addr[0] != 0) begin
      bad++; $display("FAIL stall_first_addr got=%0d want=0", (pulse_addr.size() > 0) ? pulse_addr[0] : -1);
    end
    wait_done(to);
    total++; if (to || hash_out !== ABC_DIGEST) begin bad++; $display("FAIL stall_digest got=%h want=%h", hash_out, ABC_DIGEST); end
    release_go();
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    start_run(IV, blk_empty, 1'b1);
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (pulse_addr.size() >= 31) begin
        to = 1'b0;
        break;
      end
    end
    total++; if (to) begin bad++; $display("FAIL mid_reach_round30 got=%0d pulses want=31", pulse_addr.size()); end
    reset = 1'b1;
    local_go_sig = 1'b0;
    tick();
    total++; if (w_reg_read !== 1'b0) begin bad++; $display("FAIL mid_read got=%b want=0", w_reg_read); end
    total++; if (w_reg_addr !== 6'd0) begin bad++; $display("FAIL mid_addr got=%0d want=0", w_reg_addr); end
    total++; if (hash_out !== 256'd0) begin bad++; $display("FAIL mid_hash got=%h want=0", hash_out); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", done); end
    reset = 1'b0;
    n = pulse_cyc.size();
    repeat (8) tick();
    total++; if (pulse_cyc.size() != n || done !== 1'b0) begin bad++; $display("FAIL mid_idle got=%0d reads want=%0d", pulse_cyc.size(), n); end
    start_run(IV, blk_abc, 1'b1);
    wait_done(to);
    total++; if (to || hash_out !== ABC_DIGEST) begin bad++; $display("FAIL mid_rerun_digest got=%h want=%h", hash_out, ABC_DIGEST); end
    release_go();
  endtask

  task automatic test_chain();
    bit to;
    logic [255:0] d1, expect_d;
    start_run(IV, blk_abc, 1'b1);
    wait_done(to);
    d1 = hash_out;
    total++; if (to || d1 !== ABC_DIGEST) begin bad++; $display("FAIL chain_block1 got=%h want=%h", d1, ABC_DIGEST); end
    release_go();
    start_run(d1, blk_empty, 1'b1);
    expect_d = model_compress(d1);
    wait_done(to);
    total++; if (to || hash_out !== expect_d) begin bad++; $display("FAIL chain_block2 got=%h want=%h", hash_out, expect_d); end
    release_go();
  endtask

  initial begin
    blk_abc = '0;
    blk_abc[511:480] = 32'h61626380;
    blk_abc[31:0] = 32'h00000018;
    blk_empty = '0;
    blk_empty[511:480] = 32'h80000000;
    test_reset();
    test_abc();
    test_empty();
    test_read_trace();
    test_rdy_stall();
    test_reset_mid();
    test_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
